// File: rtl/fejkon_pcie_msi_pkg.sv
// rtl/fejkon_pcie_msi_pkg.sv - shared types, widths and vector folding for the MSI arbiter
package fejkon_pcie_msi_pkg;

    localparam int MSI_NUM_W = 5;
    localparam int MAX_MME   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } msi_state_t;

    // Host may allocate fewer vectors than we have sources; low bits select the message.
    function automatic logic [MSI_NUM_W-1:0] fold_vec(input logic [MSI_NUM_W-1:0] idx,
                                                      input logic [2:0] mme);
        logic [2:0] mme_c;
        logic [MSI_NUM_W:0] mask;
        mme_c = (mme > 3'(MAX_MME)) ? 3'(MAX_MME) : mme;
        mask  = (6'd1 << mme_c) - 6'd1;
        return idx & mask[MSI_NUM_W-1:0];
    endfunction

endpackage

// File: rtl/fejkon_rr_arb.sv
// rtl/fejkon_rr_arb.sv - combinational round-robin pick of the first request at or after a pointer
module fejkon_rr_arb #(
    parameter int WIDTH = 4,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [IDXW-1:0]  i_ptr,
    output logic [WIDTH-1:0] o_gnt,
    output logic [IDXW-1:0]  o_gnt_idx,
    output logic             o_gnt_valid
);

    always_comb begin
        int pos;
        pos         = 0;
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int off = 0; off < WIDTH; off++) begin
            pos = (int'(i_ptr) + off) % WIDTH;
            if (!o_gnt_valid && i_req[pos]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = IDXW'(pos);
                o_gnt[pos]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fejkon_pcie_msi_arb.sv
// rtl/fejkon_pcie_msi_arb.sv - multi-source MSI/INTx interrupt arbiter for the PCIe hard IP
// Optional per-vector ack counters: FEJKON_MSI_STATS_EN
module fejkon_pcie_msi_arb
    import fejkon_pcie_msi_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int MSI_TC      = 0,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_VECTORS-1:0] i_irq,
    input  logic [NUM_VECTORS-1:0] i_irq_mask,
    input  logic [NUM_VECTORS-1:0] i_int_clr,
    input  logic                   i_msi_enable,
    input  logic [2:0]             i_msi_mme,
    output logic                   o_app_msi_req,
    output logic [4:0]             o_app_msi_num,
    output logic [2:0]             o_app_msi_tc,
    input  logic                   i_app_msi_ack,
    output logic                   o_app_int_sts,
    input  logic                   i_app_int_ack,
`ifdef FEJKON_MSI_STATS_EN
    input  logic [4:0]             i_stat_sel,
    output logic [31:0]            o_stat_count,
`endif
    output logic [NUM_VECTORS-1:0] o_pending,
    output logic                   o_busy
);

    localparam int IDXW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

    logic [NUM_VECTORS-1:0] r_irq_d;
    logic [NUM_VECTORS-1:0] r_pending;
    logic [IDXW-1:0]        r_ptr;
    logic [IDXW-1:0]        r_idx;
    logic [3:0]             r_gap_cnt;
    msi_state_t             r_state;
    logic                   r_msi_req;
    logic [4:0]             r_msi_num;
    logic                   r_int_sts;

    logic [NUM_VECTORS-1:0] w_rise;
    logic [NUM_VECTORS-1:0] w_eligible;
    logic [NUM_VECTORS-1:0] w_gnt;
    logic [IDXW-1:0]        w_gnt_idx;
    logic                   w_gnt_valid;
    logic                   w_ack_fire;
    logic [NUM_VECTORS-1:0] w_ack_clr;
    logic                   w_unused;

    assign w_unused   = ^{i_app_int_ack, w_gnt};
    assign w_rise     = i_irq & ~r_irq_d;
    assign w_eligible = r_pending & ~i_irq_mask;
    // An ack only retires the vector while MSI is still enabled.
    assign w_ack_fire = (r_state == ST_REQ) && i_app_msi_ack && i_msi_enable;
    assign w_ack_clr  = w_ack_fire ? (NUM_VECTORS'(1) << r_idx) : '0;

    fejkon_rr_arb #(
        .WIDTH (NUM_VECTORS),
        .IDXW  (IDXW)
    ) u_rr_arb (
        .i_req       (w_eligible),
        .i_ptr       (r_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    // A new rising edge wins over both the CSR clear and the ack clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_d   <= '0;
            r_pending <= '0;
        end else begin
            r_irq_d   <= i_irq;
            r_pending <= (r_pending & ~i_int_clr & ~w_ack_clr) | w_rise;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int_sts <= 1'b0;
        end else begin
            r_int_sts <= !i_msi_enable && (|w_eligible);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_msi_req <= 1'b0;
            r_msi_num <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_msi_enable && w_gnt_valid) begin
                        r_idx     <= w_gnt_idx;
                        r_msi_req <= 1'b1;
                        r_msi_num <= fold_vec(MSI_NUM_W'(w_gnt_idx), i_msi_mme);
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The hard IP requires req held until ack, even if MSI was disabled meanwhile.
                    if (i_app_msi_ack) begin
                        r_msi_req <= 1'b0;
                        if (i_msi_enable) begin
                            r_ptr <= (r_idx == IDXW'(NUM_VECTORS - 1)) ? '0 : r_idx + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_gap_cnt <= 4'(GAP_CYCLES - 1);
                                r_state   <= ST_GAP;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_msi_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEJKON_MSI_STATS_EN
    logic [31:0] r_stat_cnt [NUM_VECTORS];
    logic [31:0] w_stat_sel_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                if (w_ack_clr[i] && (r_stat_cnt[i] != 32'hFFFF_FFFF)) begin
                    r_stat_cnt[i] <= r_stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        w_stat_sel_cnt = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            if (i_stat_sel == 5'(i)) begin
                w_stat_sel_cnt = r_stat_cnt[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_count <= '0;
        end else begin
            o_stat_count <= w_stat_sel_cnt;
        end
    end
`endif

    assign o_app_msi_req = r_msi_req;
    assign o_app_msi_num = r_msi_num;
    assign o_app_msi_tc  = 3'(MSI_TC);
    assign o_app_int_sts = r_int_sts;
    assign o_pending     = r_pending;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fejkon_pcie_msi_arb.sv
// tb/tb_fejkon_pcie_msi_arb.sv - directed self-checking bench for fejkon_pcie_msi_arb
module tb_fejkon_pcie_msi_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq;
    logic [3:0] irq_mask;
    logic [3:0] int_clr;
    logic       msi_enable;
    logic [2:0] msi_mme;
    logic       msi_req;
    logic [4:0] msi_num;
    logic [2:0] msi_tc;
    logic       msi_ack;
    logic       int_sts;
    logic       int_ack;
    logic [3:0] pending;
    logic       busy;

    int n_pass;
    int n_total;

    fejkon_pcie_msi_arb #(
        .NUM_VECTORS (4),
        .MSI_TC      (0),
        .GAP_CYCLES  (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_irq         (irq),
        .i_irq_mask    (irq_mask),
        .i_int_clr     (int_clr),
        .i_msi_enable  (msi_enable),
        .i_msi_mme     (msi_mme),
        .o_app_msi_req (msi_req),
        .o_app_msi_num (msi_num),
        .o_app_msi_tc  (msi_tc),
        .i_app_msi_ack (msi_ack),
        .o_app_int_sts (int_sts),
        .i_app_int_ack (int_ack),
        .o_pending     (pending),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq = v;
        tick();
        irq = 4'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a request, check its number, ack it for one cycle, count gap.
    task automatic serve(input string tag, input logic [4:0] exp_num);
        int   cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (msi_req) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            tick();
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_num"}, 32'(msi_num), 32'(exp_num));
        msi_ack = 1'b1;
        tick();
        msi_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(msi_req), 32'd0);
    endtask

    // After an ack, next request must not appear for at least GAP_CYCLES cycles.
    task automatic chk_gap(input string tag);
        int low;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            if (msi_req) break;
            low++;
            tick();
        end
        chk(tag, 32'(low >= 2), 32'd1);
    endtask

    initial begin
        int spurious;
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        irq        = '0;
        irq_mask   = '0;
        int_clr    = '0;
        msi_enable = 1'b1;
        msi_mme    = 3'd2;
        msi_ack    = 1'b0;
        int_ack    = 1'b0;
        tick();
        chk("rst_req", 32'(msi_req), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_int_sts", 32'(int_sts), 32'd0);
        chk("rst_num", 32'(msi_num), 32'd0);
        chk("tc", 32'(msi_tc), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single source: exact two-cycle latency and gap length.
        irq = 4'b0100;
        tick();
        chk("single_pend", 32'(pending), 32'h4);
        chk("single_req_early", 32'(msi_req), 32'd0);
        tick();
        irq = 4'b0;
        chk("single_req", 32'(msi_req), 32'd1);
        chk("single_num", 32'(msi_num), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        msi_ack = 1'b1;
        tick();
        msi_ack = 1'b0;
        chk("single_ack_req", 32'(msi_req), 32'd0);
        chk("single_ack_pend", 32'(pending), 32'h0);
        chk("single_gap1", 32'(busy), 32'd1);
        tick();
        chk("single_gap2", 32'(busy), 32'd1);
        tick();
        chk("single_idle", 32'(busy), 32'd0);

        // Round robin from a fresh pointer.
        do_reset();
        pulse_irq(4'b1011);
        serve("rr_a", 5'd0);
        chk_gap("rr_gap_a");
        serve("rr_b", 5'd1);
        chk_gap("rr_gap_b");
        serve("rr_c", 5'd3);
        chk_gap("rr_gap_c");
        pulse_irq(4'b1001);
        serve("rr_d", 5'd0);
        chk_gap("rr_gap_d");
        serve("rr_e", 5'd3);
        chk("rr_pend_empty", 32'(pending), 32'h0);
        tick();
        tick();

        // Folding onto a smaller host allocation.
        msi_mme = 3'd0;
        pulse_irq(4'b1000);
        serve("fold_mme0", 5'd0);
        tick();
        tick();
        msi_mme = 3'd1;
        pulse_irq(4'b1000);
        serve("fold_mme1", 5'd1);
        tick();
        tick();
        tick();
        msi_mme = 3'd2;

        // Mask, then legacy INTx.
        irq_mask = 4'b0010;
        pulse_irq(4'b0010);
        tick();
        tick();
        tick();
        chk("mask_pend", 32'(pending), 32'h2);
        chk("mask_no_req", 32'(msi_req), 32'd0);
        msi_enable = 1'b0;
        irq_mask   = 4'b0;
        tick();
        chk("legacy_sts", 32'(int_sts), 32'd1);
        chk("legacy_no_req", 32'(msi_req), 32'd0);
        int_clr = 4'b0010;
        tick();
        int_clr = 4'b0;
        chk("legacy_clr_pend", 32'(pending), 32'h0);
        tick();
        chk("legacy_sts_off", 32'(int_sts), 32'd0);
        msi_enable = 1'b1;
        tick();

        // New edge on the vector being acked keeps it pending.
        pulse_irq(4'b0001);
        tick();
        chk("coll_req", 32'(msi_req), 32'd1);
        chk("coll_num", 32'(msi_num), 32'd0);
        msi_ack = 1'b1;
        irq     = 4'b0001;
        tick();
        msi_ack = 1'b0;
        irq     = 4'b0;
        chk("coll_pend", 32'(pending), 32'h1);
        chk("coll_req_drop", 32'(msi_req), 32'd0);
        serve("coll_second", 5'd0);
        chk("coll_pend_clear", 32'(pending), 32'h0);
        tick();
        tick();
        tick();

        // Asynchronous reset while a request is outstanding.
        pulse_irq(4'b0100);
        tick();
        chk("rreq_req", 32'(msi_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rreq_req0", 32'(msi_req), 32'd0);
        chk("rreq_pend0", 32'(pending), 32'h0);
        chk("rreq_busy0", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (msi_req || busy) spurious++;
        end
        chk("rreq_no_spurious", 32'(spurious), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
